// File: rtl/bsalu_pkg.sv
// Shared op encodings and FSM state type for the bit-serial ALU.
package bsalu_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_bit_slice.sv
// Combinational 1-bit AND/OR/full-add slice.
// Optional macro BSALU_SUB_EN: op=11 behaves as ADD (caller inverts b).
module alu_bit_slice
  import bsalu_pkg::*;
(
  input  logic [1:0] op,
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  output logic       r,
  output logic       cout
);

  always_comb begin
    r    = 1'b0;
    cout = 1'b0;
    case (op)
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_ADD: begin
        r    = a ^ b ^ cin;
        cout = (a & b) | (cin & (a ^ b));
      end
`ifdef BSALU_SUB_EN
      OP_SUB: begin
        r    = a ^ b ^ cin;
        cout = (a & b) | (cin & (a ^ b));
      end
`endif
      default: begin
        r    = 1'b0;
        cout = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/bit_serial_alu_ctrl.sv
// Bit-serial AND/OR/ADD sequencer: one bit per clock, LSB first, through one slice.
// Optional macro BSALU_SUB_EN enables op=11 as a-b (b inverted, carry seeded with 1).
module bit_serial_alu_ctrl
  import bsalu_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_out_q, carry_out_d;

  logic slice_b;
  logic slice_r;
  logic slice_cout;
  logic arith_op;

`ifdef BSALU_SUB_EN
  assign slice_b = (op_q == OP_SUB) ? ~b_q[0] : b_q[0];
`else
  assign slice_b = b_q[0];
`endif

  assign arith_op = (op_q == OP_ADD) || (op_q == OP_SUB);

  alu_bit_slice u_slice (
    .op   (op_q),
    .a    (a_q[0]),
    .b    (slice_b),
    .cin  (carry_q),
    .r    (slice_r),
    .cout (slice_cout)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          op_d    = op;
          cnt_d   = '0;
          sr_d    = '0;
          carry_d = 1'b0;
          if (op == OP_ADD) carry_d = carry_in;
`ifdef BSALU_SUB_EN
          if (op == OP_SUB) carry_d = 1'b1;
`endif
        end
      end
      RUN: begin
        // New bit enters at the MSB so bit 0 ends up at position 0 after WIDTH steps.
        sr_d    = {slice_r, sr_q[WIDTH-1:1]};
        carry_d = arith_op ? slice_cout : 1'b0;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d     = DONE;
          result_d    = sr_d;
          carry_out_d = carry_d;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OP_AND;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      sr_q        <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign result    = result_q;
  assign carry_out = carry_out_q;

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Scoreboard bench for bit_serial_alu_ctrl (WIDTH=8); stimulus pushes expectations, monitor checks on done.
module tb_bit_serial_alu_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       carry_in;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       carry_out;

  bit_serial_alu_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] r;
    logic       c;
    int         acc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_push = 0;
  int   n_done = 0;
  bit   b2b = 1'b0;
  int   last_done = -1;
  int   busy_run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_run = 0;
      end else begin
        if (busy) busy_run++;
        else if (busy_run != 0) begin
          chk("busy_len", busy_run, 9);
          busy_run = 0;
        end
        if (done) begin
          n_done++;
          if (sb.size() == 0) begin
            chk("spurious_done", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("result", result, e.r);
            chk("carry_out", carry_out, e.c);
            chk("latency", cyc - e.acc, 8);
            if (b2b && last_done >= 0) chk("b2b_period", cyc - last_done, 10);
            last_done = cyc;
          end
        end
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    chk("wait_idle_timeout", 1, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0) return;
      @(negedge clk);
    end
    chk("drain_timeout", sb.size(), 0);
  endtask

  task automatic issue(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                       input logic ci, input logic [7:0] er, input logic ec, input bit push);
    wait_idle();
    start = 1'b1; op = o; a = x; b = y; carry_in = ci;
    if (push) begin
      sb.push_back('{er, ec, cyc + 1});
      n_push++;
    end
    @(negedge clk);
    chk("accepted", busy, 1);
    // Captured operands must not be disturbed by later input changes.
    start = 1'b0; op = ~o; a = 8'h5A; b = 8'hC3; carry_in = ~ci;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; a = 8'h00; b = 8'h00; carry_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_carry", carry_out, 0);
    rst = 1'b0;

    issue(2'b10, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1); drain();
    issue(2'b00, 8'hA5, 8'h3C, 1'b0, 8'h24, 1'b0, 1'b1); drain();
    issue(2'b01, 8'hA5, 8'h3C, 1'b0, 8'hBD, 1'b0, 1'b1); drain();

    // Abort an ADD after bit step 4; result register held 0xBD before this.
    issue(2'b10, 8'hF0, 8'h0F, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    chk("abort_carry", carry_out, 0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    issue(2'b10, 8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b0, 1'b1); drain();

    // ADD with start pulses during RUN and in the DONE cycle.
    issue(2'b10, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && !done; i++) @(negedge clk);
    chk("saw_done", done, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_start_ignored", busy, 0);
    drain();

`ifdef BSALU_SUB_EN
    issue(2'b11, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b1); drain();
`else
    issue(2'b11, 8'h05, 8'h07, 1'b1, 8'h00, 1'b0, 1'b1); drain();
`endif

    // Back-to-back with start held high.
    b2b = 1'b1;
    last_done = -1;
    for (int k = 0; k < 3; k++) begin
      wait_idle();
      start = 1'b1;
      op = 2'b10;
      carry_in = 1'b0;
      case (k)
        0: begin a = 8'h01; b = 8'h02; sb.push_back('{8'h03, 1'b0, cyc + 1}); end
        1: begin a = 8'h80; b = 8'h80; sb.push_back('{8'h00, 1'b1, cyc + 1}); end
        default: begin a = 8'h7F; b = 8'h01; sb.push_back('{8'h80, 1'b0, cyc + 1}); end
      endcase
      n_push++;
      @(negedge clk);
      chk("b2b_accepted", busy, 1);
    end
    wait_idle();
    start = 1'b0;
    drain();
    b2b = 1'b0;
    repeat (3) @(negedge clk);

    chk("done_count", n_done, n_push);
    chk("queue_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
